spmv_ctrl: RTL

- CSR fetch sequencer placed in front of SpMV_core.
- Loads the 17-entry row-pointer array into a 136-bit bus, then walks the nonzeros: reads the value and column index, then the matching dense-vector element.
- Presents each (A, B, count) triple to the core for ELEM_CYCLES cycles, waits for the core's done, and captures its 256-bit result.

---
 rtl/spmv_pkg.sv | 26 ++
 rtl/spmv_timeout_cnt.sv | 38 +++
 rtl/spmv_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_pkg.sv
// spmv_pkg: shared constants and FSM encoding for the SpMV fetch sequencer.
// Matrix geometry, operand widths and a few FP16 reference values.
package spmv_pkg;

    localparam int N_ROWS = 16;
    localparam int PTR_W  = 8;
    localparam int DATA_W = 16;
    localparam int PTR_N  = N_ROWS + 1;

    localparam logic [DATA_W-1:0] ONE     = 16'h3C00;
    localparam logic [DATA_W-1:0] TWO     = 16'h4000;
    localparam logic [DATA_W-1:0] SIXTEEN = 16'h4C00;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_PTR,
        CHECK,
        FETCH_A,
        FETCH_B,
        ISSUE,
        HOLD,
        WAIT_DONE,
        DONE
    } state_t;

endpackage

// File: rtl/spmv_timeout_cnt.sv
// spmv_timeout_cnt: loadable down-counter with an expiry flag.
// Bounds how long the sequencer waits for the core to finish.
module spmv_timeout_cnt #(
    parameter int W = 11
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // load takes priority; count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // counter state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/spmv_ctrl.sv
// spmv_ctrl: CSR fetch sequencer feeding SpMV_core.
// Loads row pointers, streams (A, B, count) triples, captures the result.
module spmv_ctrl
    import spmv_pkg::*;
#(
    parameter int ELEM_CYCLES = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic                       o_ptr_en,
    output logic [PTR_W-1:0]           o_ptr_addr,
    input  logic [PTR_W-1:0]           i_ptr_data,
    output logic                       o_val_en,
    output logic [PTR_W-1:0]           o_val_addr,
    input  logic [DATA_W-1:0]          i_val_data,
    input  logic [PTR_W-1:0]           i_col_data,
    output logic                       o_vec_en,
    output logic [PTR_W-1:0]           o_vec_addr,
    input  logic [DATA_W-1:0]          i_vec_data,
    output logic                       o_core_start,
    output logic [DATA_W-1:0]          o_core_data_A,
    output logic [DATA_W-1:0]          o_core_data_B,
    output logic [PTR_W-1:0]           o_core_count,
    output logic [PTR_N*PTR_W-1:0]     o_core_row_ptr,
    input  logic                       i_core_done,
    input  logic [N_ROWS*DATA_W-1:0]   i_core_register,
    output logic [N_ROWS*DATA_W-1:0]   o_result
);

    localparam int HOLD_N = ELEM_CYCLES - 3;
    localparam int HOLD_W = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int IDX_W  = $clog2(PTR_N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PTR_N - 1);

    state_t                   state_q, state_d;
    logic                     ptr_en_q, ptr_en_d;
    logic [IDX_W-1:0]         ptr_idx_q, ptr_idx_d;
    logic                     cap_vld_q, cap_vld_d;
    logic [IDX_W-1:0]         cap_idx_q, cap_idx_d;
    logic [PTR_W-1:0]         row_ptr_q [PTR_N];
    logic [PTR_W-1:0]         row_ptr_d [PTR_N];
    logic                     pend_err_q, pend_err_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;
    logic [N_ROWS*DATA_W-1:0] result_q, result_d;
    logic [PTR_W-1:0]         k_q, k_d;
    logic                     val_en_q, val_en_d;
    logic [DATA_W-1:0]        a_q, a_d;
    logic [DATA_W-1:0]        core_a_q, core_a_d;
    logic [DATA_W-1:0]        core_b_q, core_b_d;
    logic [PTR_W-1:0]         count_q, count_d;
    logic                     core_start_q, core_start_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     adv;
    logic                     last_k;
    logic                     tmo_load;
    logic                     tmo_en;
    logic                     tmo_exp;
    logic [PTR_W-1:0]         nnz;

    assign nnz    = row_ptr_q[PTR_N-1];
    assign last_k = (({1'b0, k_q} + 1'b1) == {1'b0, nnz});

    spmv_timeout_cnt #(
        .W(TMO_W)
    ) u_tmo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (tmo_load),
        .i_en       (tmo_en),
        .i_load_val (TMO_W'(TIMEOUT - 1)),
        .o_expired  (tmo_exp)
    );

    // next-state and registered-output logic for the fetch sequence
    always_comb begin
        state_d      = state_q;
        ptr_en_d     = ptr_en_q;
        ptr_idx_d    = ptr_idx_q;
        cap_vld_d    = 1'b0;
        cap_idx_d    = cap_idx_q;
        row_ptr_d    = row_ptr_q;
        pend_err_d   = pend_err_q;
        err_d        = err_q;
        done_d       = 1'b0;
        result_d     = result_q;
        k_d          = k_q;
        val_en_d     = 1'b0;
        a_d          = a_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        count_d      = count_q;
        core_start_d = core_start_q;
        hold_d       = hold_q;
        adv          = 1'b0;
        tmo_load     = 1'b0;
        tmo_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = LOAD_PTR;
                    err_d      = 1'b0;
                    result_d   = '0;
                    pend_err_d = 1'b0;
                    ptr_en_d   = 1'b1;
                    ptr_idx_d  = '0;
                end
            end
            LOAD_PTR: begin
                cap_vld_d = ptr_en_q;
                cap_idx_d = ptr_idx_q;
                if (ptr_en_q) begin
                    if (ptr_idx_q == LAST_IDX) ptr_en_d = 1'b0;
                    else ptr_idx_d = ptr_idx_q + 1'b1;
                end
                if (cap_vld_q) begin
                    row_ptr_d[cap_idx_q] = i_ptr_data;
                    if ((cap_idx_q != '0) &&
                        (i_ptr_data < row_ptr_q[cap_idx_q - 1'b1]))
                        pend_err_d = 1'b1;
                    if (cap_idx_q == LAST_IDX) state_d = CHECK;
                end
            end
            CHECK: begin
                if (pend_err_q) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (nnz == '0) begin
                    result_d = '0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    k_d      = '0;
                    val_en_d = 1'b1;
                    state_d  = FETCH_A;
                end
            end
            FETCH_A: state_d = FETCH_B;
            FETCH_B: begin
                a_d     = i_val_data;
                state_d = ISSUE;
            end
            ISSUE: begin
                core_a_d     = a_q;
                core_b_d     = i_vec_data;
                count_d      = k_q + 1'b1;
                core_start_d = 1'b1;
                if (HOLD_N == 0) begin
                    adv = 1'b1;
                end else begin
                    hold_d  = HOLD_W'(HOLD_N - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == '0) adv = 1'b1;
                else hold_d = hold_q - 1'b1;
            end
            WAIT_DONE: begin
                tmo_en = 1'b1;
                if (i_core_done) begin
                    result_d     = i_core_register;
                    core_start_d = 1'b0;
                    done_d       = 1'b1;
                    state_d      = DONE;
                end else if (tmo_exp) begin
                    err_d        = 1'b1;
                    core_start_d = 1'b0;
                    done_d       = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                core_start_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (last_k) begin
                tmo_load = 1'b1;
                state_d  = WAIT_DONE;
            end else begin
                k_d      = k_q + 1'b1;
                val_en_d = 1'b1;
                state_d  = FETCH_A;
            end
        end
    end

    // state and output registers; reset aborts any operation
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            ptr_en_q     <= 1'b0;
            ptr_idx_q    <= '0;
            cap_vld_q    <= 1'b0;
            cap_idx_q    <= '0;
            for (int j = 0; j < PTR_N; j++) row_ptr_q[j] <= '0;
            pend_err_q   <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            k_q          <= '0;
            val_en_q     <= 1'b0;
            a_q          <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            count_q      <= '0;
            core_start_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_en_q     <= ptr_en_d;
            ptr_idx_q    <= ptr_idx_d;
            cap_vld_q    <= cap_vld_d;
            cap_idx_q    <= cap_idx_d;
            row_ptr_q    <= row_ptr_d;
            pend_err_q   <= pend_err_d;
            err_q        <= err_d;
            done_q       <= done_d;
            result_q     <= result_d;
            k_q          <= k_d;
            val_en_q     <= val_en_d;
            a_q          <= a_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            count_q      <= count_d;
            core_start_q <= core_start_d;
            hold_q       <= hold_d;
        end
    end

    for (genvar j = 0; j < PTR_N; j++) begin : g_rp
        assign o_core_row_ptr[j*PTR_W +: PTR_W] = row_ptr_q[j];
    end

    assign o_busy        = (state_q != IDLE);
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_ptr_en      = ptr_en_q;
    assign o_ptr_addr    = {{(PTR_W-IDX_W){1'b0}}, ptr_idx_q};
    assign o_val_en      = val_en_q;
    assign o_val_addr    = k_q;
    assign o_vec_en      = (state_q == FETCH_B);
    assign o_vec_addr    = (state_q == FETCH_B) ? i_col_data : '0;
    assign o_core_start  = core_start_q;
    assign o_core_data_A = core_a_q;
    assign o_core_data_B = core_b_q;
    assign o_core_count  = count_q;
    assign o_result      = result_q;

endmodule
